// File: rtl/sram_1rw_port_arbiter_if.sv
// Bundles both requester ports and the SRAM macro pins of the 1RW port arbiter.
// master = requesters plus macro model, slave = arbiter.
interface sram_1rw_port_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          req_a;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          gnt_a;
    logic          rvalid_a;
    logic [DW-1:0] rdata_a;

    logic          req_b;
    logic [AW-1:0] addr_b;
    logic          gnt_b;
    logic          rvalid_b;
    logic [DW-1:0] rdata_b;

    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;

    modport master (
        output req_a, we_a, addr_a, din_a, req_b, addr_b, dout0,
        input  gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b,
        input  csb0, web0, addr0, din0
    );

    modport slave (
        input  req_a, we_a, addr_a, din_a, req_b, addr_b, dout0,
        output gnt_a, rvalid_a, rdata_a, gnt_b, rvalid_b, rdata_b,
        output csb0, web0, addr0, din0
    );
endinterface

// File: rtl/sram_1rw_port_arbiter.sv
// Round-robin share of one 1RW SRAM macro: port A read/write, port B read-only; grant is combinational,
// read data returns RD_LAT+1 cycles after grant; requesters hold req until gnt. Optional: SRAM_ARB_CONFLICT_CNT_EN.
module sram_1rw_port_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_1rw_port_arbiter_if.slave bus
`ifdef SRAM_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]            conflict_cnt
`endif
);

    logic              last_gnt_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              rd_issue;
    logic [AW-1:0]     addr_mux;
    logic [AW-1:0]     addr_hold;
    logic [DW-1:0]     din_hold;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own_b;
    logic              rvalid_a_q;
    logic              rvalid_b_q;
    logic [DW-1:0]     rdata_a_q;
    logic [DW-1:0]     rdata_b_q;

    // On conflict the port that did not win last time goes; reset leaves B as last winner.
    assign gnt_a    = rst_n & bus.req_a & (~bus.req_b | last_gnt_b);
    assign gnt_b    = rst_n & bus.req_b & ~gnt_a;
    assign rd_issue = (gnt_a & ~bus.we_a) | gnt_b;

    assign addr_mux = gnt_a ? bus.addr_a : (gnt_b ? bus.addr_b : addr_hold);

    assign bus.gnt_a    = gnt_a;
    assign bus.gnt_b    = gnt_b;
    assign bus.csb0     = ~(gnt_a | gnt_b);
    assign bus.web0     = ~(gnt_a & bus.we_a);
    assign bus.addr0    = addr_mux;
    assign bus.din0     = gnt_a ? bus.din_a : din_hold;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_b <= 1'b1;
            addr_hold  <= '0;
            din_hold   <= '0;
            tag_vld    <= '0;
            tag_own_b  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            if (gnt_a | gnt_b) begin
                last_gnt_b <= gnt_b;
                addr_hold  <= addr_mux;
            end
            if (gnt_a) begin
                din_hold <= bus.din_a;
            end

            // Tag walks alongside the macro's read pipe; its exit lines up with valid dout0.
            tag_vld[0]   <= rd_issue;
            tag_own_b[0] <= gnt_b;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]   <= tag_vld[i-1];
                tag_own_b[i] <= tag_own_b[i-1];
            end

            rvalid_a_q <= tag_vld[RD_LAT-1] & ~tag_own_b[RD_LAT-1];
            rvalid_b_q <= tag_vld[RD_LAT-1] &  tag_own_b[RD_LAT-1];
            if (tag_vld[RD_LAT-1] && !tag_own_b[RD_LAT-1]) begin
                rdata_a_q <= bus.dout0;
            end
            if (tag_vld[RD_LAT-1] && tag_own_b[RD_LAT-1]) begin
                rdata_b_q <= bus.dout0;
            end
        end
    end

`ifdef SRAM_ARB_CONFLICT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (bus.req_a && bus.req_b && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule
